// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for CPU pipeline-stage registers.
// The skid-buffer occupancy encoding is shared by every stage that uses one.
package cpu_pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle around one pipeline stage register.
// The master side is the producer/consumer environment; the slave side is the stage itself.
interface pipe_stage_reg_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready flow control and flush.
// SKID=0 is a single entry with combinational ready; SKID=1 adds a skid entry so in_ready is registered.
module pipe_stage_reg
  import cpu_pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               SKID      = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic              clk,
  input logic              rst_n,
  input logic              flush,
  pipe_stage_reg_if.slave  bus
);

  if (SKID != 0) begin : gSkid
    skid_state_e      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             inReady_q;
    logic             outValid_q;
    logic             xferIn;
    logic             xferOut;

    assign xferIn  = bus.in_valid && inReady_q;
    assign xferOut = outValid_q && bus.out_ready;

    // Flush wins over every handshake; data registers are left untouched so out_data keeps its value.
    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
        state_d = EMPTY;
      end else begin
        case (state_q)
          EMPTY: begin
            if (xferIn) begin
              state_d = BUSY;
              main_d  = bus.in_data;
            end
          end
          BUSY: begin
            if (xferIn && xferOut) begin
              main_d = bus.in_data;
            end else if (xferIn) begin
              state_d = FULL;
              skid_d  = bus.in_data;
            end else if (xferOut) begin
              state_d = EMPTY;
            end
          end
          FULL: begin
            if (xferOut) begin
              state_d = BUSY;
              main_d  = skid_q;
            end
          end
          default: state_d = EMPTY;
        endcase
      end
    end

    // Ready and valid are registered from the next state, breaking any out_ready -> in_ready path.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q    <= EMPTY;
        main_q     <= RESET_VAL;
        skid_q     <= RESET_VAL;
        inReady_q  <= 1'b1;
        outValid_q <= 1'b0;
      end else begin
        state_q    <= state_d;
        main_q     <= main_d;
        skid_q     <= skid_d;
        inReady_q  <= (state_d != FULL);
        outValid_q <= (state_d != EMPTY);
      end
    end

    assign bus.in_ready  = inReady_q;
    assign bus.out_valid = outValid_q;
    assign bus.out_data  = main_q;

  end else begin : gPlain
    logic [WIDTH-1:0] main_q;
    logic             outValid_q;
    logic             inReady;
    logic             xferIn;
    logic             xferOut;

    assign inReady = !outValid_q || bus.out_ready;
    assign xferIn  = bus.in_valid && inReady;
    assign xferOut = outValid_q && bus.out_ready;

    // A flushed handshake still completes on the bus, but the word is never captured.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        main_q     <= RESET_VAL;
        outValid_q <= 1'b0;
      end else if (flush) begin
        outValid_q <= 1'b0;
      end else if (xferIn) begin
        main_q     <= bus.in_data;
        outValid_q <= 1'b1;
      end else if (xferOut) begin
        outValid_q <= 1'b0;
      end
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid_q;
    assign bus.out_data  = main_q;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed skid and plain-mode scenarios, then random traffic.
// A per-instance scoreboard queue holds words accepted upstream until they leave downstream.
module tb_pipe_stage_reg;

  logic clk;
  logic rst_n;
  logic flushS;
  logic flushN;
  logic flushR;

  int total;
  int bad;

  logic [63:0] sb[4][$];
  logic        prevStall[4];
  logic [63:0] prevData[4];

  pipe_stage_reg_if #(.WIDTH(32)) sIf ();
  pipe_stage_reg_if #(.WIDTH(32)) nIf ();
  pipe_stage_reg_if #(.WIDTH(1))  w1If ();
  pipe_stage_reg_if #(.WIDTH(64)) w64If ();

  pipe_stage_reg #(.WIDTH(32), .SKID(1), .RESET_VAL(32'hDEAD_BEEF)) dutS (
    .clk(clk), .rst_n(rst_n), .flush(flushS), .bus(sIf)
  );
  pipe_stage_reg #(.WIDTH(32), .SKID(0), .RESET_VAL(32'h0000_1234)) dutN (
    .clk(clk), .rst_n(rst_n), .flush(flushN), .bus(nIf)
  );
  pipe_stage_reg #(.WIDTH(1), .SKID(1), .RESET_VAL(1'b1)) dutW1 (
    .clk(clk), .rst_n(rst_n), .flush(flushR), .bus(w1If)
  );
  pipe_stage_reg #(.WIDTH(64), .SKID(0), .RESET_VAL(64'h0)) dutW64 (
    .clk(clk), .rst_n(rst_n), .flush(flushR), .bus(w64If)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pop/compare on a transfer out, then drop everything on flush or record a transfer in.
  task automatic scoreStep(input int k, input logic ov, input logic ordy, input logic [63:0] od,
                           input logic fl, input logic iv, input logic ir, input logic [63:0] id);
    logic [63:0] exp;
    if (prevStall[k]) checkOutput($sformatf("stable%0d", k), od, prevData[k]);
    if (ov && ordy) begin
      exp = 'x;
      if (sb[k].size() != 0) exp = sb[k].pop_front();
      checkOutput($sformatf("order%0d", k), od, exp);
    end
    if (fl) sb[k].delete();
    else if (iv && ir) sb[k].push_back(id);
    prevStall[k] = ov && !ordy;
    prevData[k]  = od;
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    scoreStep(0, sIf.out_valid, sIf.out_ready, 64'(sIf.out_data), flushS,
              sIf.in_valid, sIf.in_ready, 64'(sIf.in_data));
    scoreStep(1, nIf.out_valid, nIf.out_ready, 64'(nIf.out_data), flushN,
              nIf.in_valid, nIf.in_ready, 64'(nIf.in_data));
    scoreStep(2, w1If.out_valid, w1If.out_ready, 64'(w1If.out_data), flushR,
              w1If.in_valid, w1If.in_ready, 64'(w1If.in_data));
    scoreStep(3, w64If.out_valid, w64If.out_ready, w64If.out_data, flushR,
              w64If.in_valid, w64If.in_ready, w64If.in_data);
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    flushS = 1'b0; flushN = 1'b0; flushR = 1'b0;
    sIf.in_valid = 1'b0;   sIf.in_data = '0;   sIf.out_ready = 1'b0;
    nIf.in_valid = 1'b0;   nIf.in_data = '0;   nIf.out_ready = 1'b0;
    w1If.in_valid = 1'b0;  w1If.in_data = '0;  w1If.out_ready = 1'b0;
    w64If.in_valid = 1'b0; w64If.in_data = '0; w64If.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      prevStall[k] = 1'b0;
      prevData[k]  = '0;
    end

    applyStimulus();
    applyStimulus();
    $display("[TB] reset state");
    checkOutput("rstS_valid", 64'(sIf.out_valid), 64'd0);
    checkOutput("rstS_data", 64'(sIf.out_data), 64'hDEAD_BEEF);
    checkOutput("rstS_ready", 64'(sIf.in_ready), 64'd1);
    checkOutput("rstN_data", 64'(nIf.out_data), 64'h1234);
    checkOutput("rstN_ready", 64'(nIf.in_ready), 64'd1);
    rst_n = 1'b1;

    $display("[TB] streaming skid mode");
    sIf.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      sIf.in_valid = 1'b1;
      sIf.in_data  = 32'(i);
      #1;
      checkOutput($sformatf("streamReady%0d", i), 64'(sIf.in_ready), 64'd1);
      applyStimulus();
      if (i == 1) begin
        checkOutput("latencyValid", 64'(sIf.out_valid), 64'd1);
        checkOutput("latencyData", 64'(sIf.out_data), 64'h1);
      end
    end
    sIf.in_valid = 1'b0;
    applyStimulus();
    checkOutput("streamDrainValid", 64'(sIf.out_valid), 64'd0);
    checkOutput("streamDrainQueue", 64'(sb[0].size()), 64'd0);

    $display("[TB] backpressure skid mode");
    sIf.out_ready = 1'b0;
    sIf.in_valid  = 1'b1;
    sIf.in_data   = 32'hA;
    applyStimulus();
    sIf.in_data = 32'hB;
    applyStimulus();
    checkOutput("bpFullReady", 64'(sIf.in_ready), 64'd0);
    sIf.in_data = 32'hC;
    applyStimulus();
    checkOutput("bpHoldReady", 64'(sIf.in_ready), 64'd0);
    checkOutput("bpHoldValid", 64'(sIf.out_valid), 64'd1);
    checkOutput("bpHoldData", 64'(sIf.out_data), 64'hA);
    checkOutput("bpAccepted", 64'(sb[0].size()), 64'd2);
    sIf.out_ready = 1'b1;
    applyStimulus();
    checkOutput("bpSkidData", 64'(sIf.out_data), 64'hB);
    checkOutput("bpReadyBack", 64'(sIf.in_ready), 64'd1);
    applyStimulus();
    checkOutput("bpLastData", 64'(sIf.out_data), 64'hC);
    sIf.in_valid = 1'b0;
    applyStimulus();
    checkOutput("bpEmpty", 64'(sIf.out_valid), 64'd0);

    $display("[TB] flush skid mode");
    sIf.out_ready = 1'b0;
    sIf.in_valid  = 1'b1;
    sIf.in_data   = 32'h11;
    applyStimulus();
    sIf.in_data = 32'h22;
    applyStimulus();
    checkOutput("flFullReady", 64'(sIf.in_ready), 64'd0);
    flushS = 1'b1;
    sIf.in_data = 32'h33;
    applyStimulus();
    flushS = 1'b0;
    sIf.in_valid = 1'b0;
    checkOutput("flValid", 64'(sIf.out_valid), 64'd0);
    checkOutput("flReady", 64'(sIf.in_ready), 64'd1);
    checkOutput("flDataKept", 64'(sIf.out_data), 64'h11);
    sIf.out_ready = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("flStaysEmpty", 64'(sIf.out_valid), 64'd0);
    sIf.out_ready = 1'b0;
    sIf.in_valid  = 1'b1;
    sIf.in_data   = 32'h55;
    applyStimulus();
    flushS = 1'b1;
    sIf.in_data   = 32'h44;
    sIf.out_ready = 1'b1;
    #1;
    checkOutput("flBusyReady", 64'(sIf.in_ready), 64'd1);
    applyStimulus();
    flushS = 1'b0;
    sIf.in_valid = 1'b0;
    checkOutput("flBusyValid", 64'(sIf.out_valid), 64'd0);
    checkOutput("flBusyData", 64'(sIf.out_data), 64'h55);

    $display("[TB] asynchronous reset from FULL");
    sIf.out_ready = 1'b0;
    sIf.in_valid  = 1'b1;
    sIf.in_data   = 32'h66;
    applyStimulus();
    sIf.in_data = 32'h77;
    applyStimulus();
    sIf.in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    checkOutput("arstValid", 64'(sIf.out_valid), 64'd0);
    checkOutput("arstData", 64'(sIf.out_data), 64'hDEAD_BEEF);
    checkOutput("arstReady", 64'(sIf.in_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      sb[k].delete();
      prevStall[k] = 1'b0;
    end
    applyStimulus();
    rst_n = 1'b1;

    $display("[TB] plain register mode");
    nIf.out_ready = 1'b0;
    nIf.in_valid  = 1'b1;
    nIf.in_data   = 32'h100;
    #1;
    checkOutput("nEmptyReady", 64'(nIf.in_ready), 64'd1);
    applyStimulus();
    nIf.in_data = 32'h200;
    #1;
    checkOutput("nStallReady", 64'(nIf.in_ready), 64'd0);
    applyStimulus();
    checkOutput("nStallData", 64'(nIf.out_data), 64'h100);
    checkOutput("nStallValid", 64'(nIf.out_valid), 64'd1);
    nIf.out_ready = 1'b1;
    #1;
    checkOutput("nCombReady", 64'(nIf.in_ready), 64'd1);
    applyStimulus();
    checkOutput("nReplaceData", 64'(nIf.out_data), 64'h200);
    checkOutput("nReplaceValid", 64'(nIf.out_valid), 64'd1);
    nIf.in_valid = 1'b0;
    applyStimulus();
    checkOutput("nDrainValid", 64'(nIf.out_valid), 64'd0);
    nIf.out_ready = 1'b0;
    nIf.in_valid  = 1'b1;
    nIf.in_data   = 32'h300;
    applyStimulus();
    flushN = 1'b1;
    nIf.in_data = 32'h400;
    applyStimulus();
    flushN = 1'b0;
    nIf.in_valid = 1'b0;
    checkOutput("nFlushValid", 64'(nIf.out_valid), 64'd0);
    checkOutput("nFlushData", 64'(nIf.out_data), 64'h300);
    checkOutput("nFlushReady", 64'(nIf.in_ready), 64'd1);

    $display("[TB] random traffic WIDTH=1 skid and WIDTH=64 plain");
    for (int c = 0; c < 400; c++) begin
      w1If.in_valid   = 1'($urandom_range(0, 1));
      w1If.in_data    = 1'($urandom_range(0, 1));
      w1If.out_ready  = ($urandom_range(0, 3) != 0);
      w64If.in_valid  = 1'($urandom_range(0, 1));
      w64If.in_data   = {$urandom, $urandom};
      w64If.out_ready = ($urandom_range(0, 2) != 0);
      applyStimulus();
    end
    w1If.in_valid   = 1'b0;
    w64If.in_valid  = 1'b0;
    w1If.out_ready  = 1'b1;
    w64If.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) applyStimulus();
    checkOutput("rndW1Drained", 64'(sb[2].size()), 64'd0);
    checkOutput("rndW64Drained", 64'(sb[3].size()), 64'd0);
    checkOutput("rndW1Idle", 64'(w1If.out_valid), 64'd0);
    checkOutput("rndW64Idle", 64'(w64If.out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
